// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state type.
package mmio_pkg;

  localparam logic [1:0] TXDATA_OFS = 2'd0;
  localparam logic [1:0] STATUS_OFS = 2'd1;
  localparam logic [1:0] CTRL_OFS   = 2'd2;

  localparam int STAT_ACTIVE_BIT = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_EMPTY_BIT  = 2;
  localparam int STAT_OVF_BIT    = 3;
  localparam int STAT_COUNT_LSB  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; pushes while full and
// pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: CPU stores fill a TX FIFO that is sent 8N1 on txd.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
//
// state     | meaning
// ST_IDLE   | line idle (txd=1), pops next byte when FIFO non-empty
// ST_START  | start bit (txd=0)
// ST_DATA   | 8 data bits, LSB first
// ST_PARITY | even parity bit (parity builds only)
// ST_STOP   | stop bit (txd=1)
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic        sel,
  output logic [31:0] rd,
  output logic        txd,
  output logic        tx_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);

  uart_tx_state_t state;
  logic [TW-1:0]  timer;
  logic [2:0]     idx;
  logic [7:0]     shreg;
  logic           txd_q;
  logic           overflow;

  logic [1:0]     ofs;
  logic           wr_txdata;
  logic           wr_ctrl;
  logic           fifo_pop;
  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [31:0]    status;
  logic           unused_bits;

  assign ofs       = addr[3:2];
  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_txdata = memwrite && sel && (ofs == TXDATA_OFS);
  assign wr_ctrl   = memwrite && sel && (ofs == CTRL_OFS);
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign unused_bits = ^{wd[31:8], addr[1:0]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status                  = '0;
    status[STAT_ACTIVE_BIT] = (state != ST_IDLE);
    status[STAT_FULL_BIT]   = fifo_full;
    status[STAT_EMPTY_BIT]  = fifo_empty;
    status[STAT_OVF_BIT]    = overflow;
    status[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
  end

  assign rd      = (sel && (ofs == STATUS_OFS)) ? status : 32'h0;
  assign txd     = txd_q;
  assign tx_busy = (state != ST_IDLE) || !fifo_empty;

  // A dropped push outranks a clear landing on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wr_txdata && fifo_full) begin
      overflow <= 1'b1;
    end else if (wr_ctrl && wd[0]) begin
      overflow <= 1'b0;
    end
  end

`ifdef MMIO_UART_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        par_q <= 1'b0;
    else if (fifo_pop) par_q <= ^fifo_dout;
  end
`endif

  // txd is registered from the transition itself so it changes on the same
  // edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      timer <= '0;
      idx   <= '0;
      shreg <= '0;
      txd_q <= 1'b1;
    end else if (state == ST_IDLE) begin
      if (fifo_pop) begin
        state <= ST_START;
        timer <= TIMER_RELOAD;
        shreg <= fifo_dout;
        txd_q <= 1'b0;
      end
    end else if (timer != '0) begin
      timer <= timer - TW'(1);
    end else begin
      timer <= TIMER_RELOAD;
      case (state)
        ST_START: begin
          state <= ST_DATA;
          idx   <= '0;
          txd_q <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
        ST_DATA: begin
          if (idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state <= ST_PARITY;
            txd_q <= par_q;
`else
            state <= ST_STOP;
            txd_q <= 1'b1;
`endif
          end else begin
            idx   <= idx + 3'd1;
            txd_q <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        ST_PARITY: begin
          state <= ST_STOP;
          txd_q <= 1'b1;
        end
`endif
        ST_STOP: begin
          state <= ST_IDLE;
          timer <= '0;
          txd_q <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
          txd_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the ktc32 data bus, where it is a responder to CPU stores and loads. Decoded from the same `memwrite`/`addr`/`wd`/`rd` signals that drive `ram`. CPU stores place bytes into a TX FIFO, and the block serialises them 8N1 on `txd`. Benches and FPGA builds use it to report results, for example printing a computed Fibonacci value, instead of only watching store addresses.

## Interface
- `BASE_ADDR`, default 32'h0000_1000: base of a 16-byte register window; must be 16-byte aligned.
- `CLKS_PER_BIT`, default 16: `clk` cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of 2 and ≥ 2.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `memwrite` input, 1 bit: CPU store strobe, valid for one cycle.
- `addr` input, 32 bits: CPU byte address.
- `wd` input, 32 bits: CPU store data.
- `sel` output, 1 bit: combinational; high when `addr[31:4] == BASE_ADDR[31:4]`. The top level uses it to mux `rd` and gate `ram` writes.
- `rd` output, 32 bits: combinational read data for `addr`; 0 when `sel` is low.
- `txd` output, 1 bit: registered serial line; idle level is 1.
- `tx_busy` output, 1 bit: high while a frame is being shifted or the FIFO is non-empty.

## Operation
- Register map, decoded on `addr[3:2]`; `addr[1:0]` is ignored.
  - +0 TXDATA. A write pushes `wd[7:0]`; `wd[31:8]` is ignored. Reads return 0.
  - +4 STATUS, read-only:
    - bit0: shifter active.
    - bit1: FIFO full.
    - bit2: FIFO empty.
    - bit3: overflow (sticky).
    - bits[15:8]: FIFO count.
    - Other bits read 0.
  - +8 CTRL. A write with `wd[0]=1` clears overflow. Reads return 0.
  - +C is reserved. Reads return 0; writes are ignored.
- Push rule: a TXDATA write when the FIFO is full, with fullness evaluated at the start of the cycle, is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
- Pop rule: when the FSM is in IDLE and the FIFO is non-empty, pop one byte into the shift register and go to START. A push and a pop in the same cycle leave the count unchanged.
- FSM states, each bit state lasting exactly `CLKS_PER_BIT` cycles, counted by a bit-timer:
  - IDLE (`txd`=1).
  - START (`txd`=0).
  - DATA: 8 bits, LSB first, counted by a 3-bit index.
  - PARITY: present only if the macro is defined.
  - STOP (`txd`=1), then back to IDLE.
- Back-to-back frames: STOP → IDLE → START, with exactly one extra idle cycle between frames.
- Reset values:
  - `txd`=1, `tx_busy`=0.
  - FSM in IDLE, FIFO empty, count 0, overflow 0, bit-timer 0.
  - `rd` and `sel` follow `addr` combinationally.
- Reset mid-frame: `txd` returns to 1 asynchronously and the FIFO contents are discarded.

## Timing
- A store is sampled at rising edge N. The byte is in the FIFO after N.
- If the block was idle and the FIFO was empty, the pop happens at N+1 and `txd` falls after N+1.
- A frame occupies `txd` for (10 + parity) × `CLKS_PER_BIT` cycles.
- STATUS reflects state registered at the most recent edge. A store's effect on STATUS is visible the cycle after the store.
- Overflow sets at the edge of the dropped write. A CTRL clear and a dropped write at the same edge leave overflow set.

## Configuration
- `MMIO_UART_TX_PARITY_EN` defined: a PARITY state is inserted after DATA and transmits even parity (XOR of the 8 data bits). The frame is 11 bits long.
- Not defined: frames are 8N1 (10 bits), and no parity logic is generated.

## Structure
- Package `mmio_pkg` holds:
  - register offset constants: `TXDATA_OFS`, `STATUS_OFS`, `CTRL_OFS`;
  - STATUS bit index constants;
  - the `uart_tx_state_t` enum.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) with ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`. It uses the same clock and reset. `mmio_uart_tx` contains the decode logic, the FSM and the shifter.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 unless stated otherwise.
- Reset, then idle: `txd`=1, `tx_busy`=0, and a STATUS read returns 32'h0000_0004.
- Store 32'h0000_0090 to BASE+0 (the Fibonacci result 144): `txd` sequence is 0 | 0,0,0,0,1,0,0,1 | 1, each bit 4 cycles, starting one cycle after the store. `tx_busy` falls after the stop bit.
- 10 back-to-back TXDATA stores of 0x01..0x0A:
  - STATUS reads count=8, full=1, overflow=1.
  - Bytes 0x01..0x09 appear on `txd` in order and 0x0A never does.
  - A CTRL write of 1 clears overflow.
- Assert reset low mid-DATA of a 0x55 frame with 3 bytes queued: `txd`=1 immediately, and after release STATUS=32'h0000_0004 and no further frames are sent.
- Store to BASE+C and to BASE+16: FIFO unchanged. `sel` is low for BASE+16 and `rd` is 0 for both.
- With `MMIO_UART_TX_PARITY_EN` defined, store 0x07: parity bit 1, the frame is 11 bits × 4 cycles, and the stop bit is 1.
